// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op codes, forward selects, FSM states.
package ex_pkg;

  typedef logic [3:0] aluop_t;

  localparam aluop_t ALU_ADD   = 4'b0000;
  localparam aluop_t ALU_SUB   = 4'b0001;
  localparam aluop_t ALU_AND   = 4'b0010;
  localparam aluop_t ALU_OR    = 4'b0011;
  localparam aluop_t ALU_XOR   = 4'b0100;
  localparam aluop_t ALU_SLL   = 4'b0101;
  localparam aluop_t ALU_SRL   = 4'b0110;
  localparam aluop_t ALU_SRA   = 4'b0111;
  localparam aluop_t ALU_SLT   = 4'b1000;
  localparam aluop_t ALU_SLTU  = 4'b1001;
  localparam aluop_t ALU_MUL   = 4'b1010;
  localparam aluop_t ALU_PASSB = 4'b1011;

  typedef logic [1:0] fwd_t;

  localparam fwd_t FWD_REG = 2'b00;
  localparam fwd_t FWD_MEM = 2'b10;
  localparam fwd_t FWD_WB  = 2'b01;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE     = 2'd0;
  localparam state_t S_MUL_RUN  = 2'd1;
  localparam state_t S_MUL_DONE = 2'd2;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX operands, forwarding/control inputs and EX/MEM register outputs of the execute stage.
interface ex_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic            in_alusrc;
  logic [3:0]      in_aluop;
  logic [4:0]      in_rd;
  logic            in_regwrite;
  logic            in_memread;
  logic            in_memwrite;
  logic            in_memtoreg;
  logic [1:0]      forwardA;
  logic [1:0]      forwardB;
  logic [XLEN-1:0] exmem_fwd_data;
  logic [XLEN-1:0] wb_fwd_data;
  logic            flush;
  logic            hold;
  logic            stall_req;
  logic            exmem_valid;
  logic            exmem_regwrite;
  logic            exmem_memread;
  logic            exmem_memwrite;
  logic            exmem_memtoreg;
  logic [4:0]      exmem_rd;
  logic [XLEN-1:0] exmem_alu_result;
  logic [XLEN-1:0] exmem_store_data;

  modport slave (
    input  in_valid, in_rs1_data, in_rs2_data, in_imm, in_alusrc, in_aluop, in_rd,
           in_regwrite, in_memread, in_memwrite, in_memtoreg,
           forwardA, forwardB, exmem_fwd_data, wb_fwd_data, flush, hold,
    output stall_req, exmem_valid, exmem_regwrite, exmem_memread, exmem_memwrite,
           exmem_memtoreg, exmem_rd, exmem_alu_result, exmem_store_data
  );

  modport master (
    output in_valid, in_rs1_data, in_rs2_data, in_imm, in_alusrc, in_aluop, in_rd,
           in_regwrite, in_memread, in_memwrite, in_memtoreg,
           forwardA, forwardB, exmem_fwd_data, wb_fwd_data, flush, hold,
    input  stall_req, exmem_valid, exmem_regwrite, exmem_memread, exmem_memwrite,
           exmem_memtoreg, exmem_rd, exmem_alu_result, exmem_store_data
  );
endinterface

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, low XLEN bits kept.
module mul_iter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            hold,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);
  localparam int unsigned CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [CW-1:0]   count;
  logic            busy;

  // Final step is being taken this cycle (ignoring hold; the FSM also gates on hold).
  assign done    = busy && (count == LAST);
  assign product = acc;

  // Load operands on start, then add/shift once per unfrozen cycle until the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else if (abort) begin
      count <= '0;
      busy  <= 1'b0;
    end else if (hold) begin
      busy <= busy;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      count  <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= {mcand[XLEN-2:0], 1'b0};
      mplier <= {1'b0, mplier[XLEN-1:1]};
      if (count == LAST) begin
        count <= '0;
        busy  <= 1'b0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: operand forwarding, ALU, iterative multiply and the EX/MEM register.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input logic      clk,
  input logic      rst,
  ex_stage_if.slave bus
);
  state_t          state;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic            is_mul;
  logic            mul_start;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;
  logic            stall;

  logic            nxt_valid;
  logic            nxt_regwrite;
  logic            nxt_memread;
  logic            nxt_memwrite;
  logic            nxt_memtoreg;
  logic [4:0]      nxt_rd;
  logic [XLEN-1:0] nxt_result;
  logic [XLEN-1:0] nxt_store;

  assign is_mul    = (bus.in_aluop == ALU_MUL);
  assign mul_start = (state == S_IDLE) && bus.in_valid && is_mul && !bus.flush && !bus.hold;

  // Forwarding muxes and ALU; select 11 falls back to the register file.
  always_comb begin
    unique case (bus.forwardA)
      FWD_MEM: op_a = bus.exmem_fwd_data;
      FWD_WB:  op_a = bus.wb_fwd_data;
      default: op_a = bus.in_rs1_data;
    endcase
    unique case (bus.forwardB)
      FWD_MEM: fwd_b = bus.exmem_fwd_data;
      FWD_WB:  fwd_b = bus.wb_fwd_data;
      default: fwd_b = bus.in_rs2_data;
    endcase
    op_b = bus.in_alusrc ? bus.in_imm : fwd_b;

    alu_result = '0;
    case (bus.in_aluop)
      ALU_ADD:   alu_result = op_a + op_b;
      ALU_SUB:   alu_result = op_a - op_b;
      ALU_AND:   alu_result = op_a & op_b;
      ALU_OR:    alu_result = op_a | op_b;
      ALU_XOR:   alu_result = op_a ^ op_b;
      ALU_SLL:   alu_result = op_a << op_b[4:0];
      ALU_SRL:   alu_result = op_a >> op_b[4:0];
      ALU_SRA:   alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
      ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_PASSB: alu_result = op_b;
      default:   alu_result = '0;
    endcase
  end

  mul_iter #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .hold    (bus.hold),
    .abort   (bus.flush),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Multiply sequencing; flush aborts, hold freezes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else if (!bus.hold) begin
      case (state)
        S_IDLE:     if (bus.in_valid && is_mul) state <= S_MUL_RUN;
        S_MUL_RUN:  if (mul_done) state <= S_MUL_DONE;
        S_MUL_DONE: state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  // Upstream stall while a multiply is being launched or is iterating.
  always_comb begin
    stall = 1'b0;
    if (!rst && !bus.flush) begin
      case (state)
        S_IDLE:    stall = bus.in_valid && is_mul;
        S_MUL_RUN: stall = 1'b1;
        default:   stall = 1'b0;
      endcase
    end
  end

  assign bus.stall_req = stall;

  // Next EX/MEM contents: ALU result in IDLE, product in MUL_DONE, bubble otherwise.
  always_comb begin
    nxt_valid    = 1'b0;
    nxt_regwrite = 1'b0;
    nxt_memread  = 1'b0;
    nxt_memwrite = 1'b0;
    nxt_memtoreg = 1'b0;
    nxt_rd       = '0;
    nxt_result   = '0;
    nxt_store    = '0;
    if (!bus.flush) begin
      if ((state == S_IDLE && bus.in_valid && !is_mul) || state == S_MUL_DONE) begin
        nxt_valid    = 1'b1;
        nxt_regwrite = bus.in_regwrite;
        nxt_memread  = bus.in_memread;
        nxt_memwrite = bus.in_memwrite;
        nxt_memtoreg = bus.in_memtoreg;
        nxt_rd       = bus.in_rd;
        nxt_result   = (state == S_MUL_DONE) ? mul_product : alu_result;
        nxt_store    = fwd_b;
      end
    end
  end

  // EX/MEM pipeline register; flush overrides hold so a squash always lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.exmem_valid      <= 1'b0;
      bus.exmem_regwrite   <= 1'b0;
      bus.exmem_memread    <= 1'b0;
      bus.exmem_memwrite   <= 1'b0;
      bus.exmem_memtoreg   <= 1'b0;
      bus.exmem_rd         <= '0;
      bus.exmem_alu_result <= '0;
      bus.exmem_store_data <= '0;
    end else if (bus.flush || !bus.hold) begin
      bus.exmem_valid      <= nxt_valid;
      bus.exmem_regwrite   <= nxt_regwrite;
      bus.exmem_memread    <= nxt_memread;
      bus.exmem_memwrite   <= nxt_memwrite;
      bus.exmem_memtoreg   <= nxt_memtoreg;
      bus.exmem_rd         <= nxt_rd;
      bus.exmem_alu_result <= nxt_result;
      bus.exmem_store_data <= nxt_store;
    end
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32 pipeline. Consumes ID/EX operands and the forwardA/forwardB selects from the forwarding unit, and resolves operands from the register file, EX/MEM or MEM/WB. Computes the ALU result, or runs an iterative 32-cycle multiply, and owns the EX/MEM pipeline register. That register's rd/regwrite/result feed forwarding on the next cycle.

## Interface
- XLEN, 32, datapath width
- MUL_CYCLES, 32, multiply iterations (equals XLEN)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  ID/EX holds a live instruction
- in_rs1_data, in_rs2_data  input  XLEN  register-file operands
- in_imm  input  XLEN  sign-extended immediate
- in_alusrc  input  1  1 = operand B is in_imm
- in_aluop  input  4  ALU operation (codes in ex_pkg)
- in_rd  input  5  destination register
- in_regwrite, in_memread, in_memwrite, in_memtoreg  input  1 each  control bits carried to EX/MEM
- forwardA, forwardB  input  2  00 regfile, 10 EX/MEM, 01 MEM/WB, 11 treated as 00
- exmem_fwd_data  input  XLEN  EX/MEM result for forwarding; top-level ties it to exmem_alu_result
- wb_fwd_data  input  XLEN  MEM/WB writeback value
- flush  input  1  squash the instruction in EX
- hold  input  1  downstream stall; freeze EX/MEM and multiplier
- stall_req  output  1  upstream must hold PC, IF/ID and ID/EX
- exmem_valid, exmem_regwrite, exmem_memread, exmem_memwrite, exmem_memtoreg  output  1 each  registered control
- exmem_rd  output  5  registered destination
- exmem_alu_result  output  XLEN  registered result or address
- exmem_store_data  output  XLEN  registered forwarded rs2

## Operation
- Operand A is selected by forwardA. Forwarded B (fwdB) is selected by forwardB. Operand B = in_alusrc ? in_imm : fwdB. Store data is always fwdB.
- ALU ops:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA: shift amount is B[4:0]
  - 1000 SLT (signed), 1001 SLTU
  - 1010 MUL: low XLEN bits of the product, iterative
  - 1011 PASSB: LUI
  - 1100–1111 produce 0
- All arithmetic is modulo 2^XLEN with no overflow flag.
- FSM states: IDLE, MUL_RUN, MUL_DONE.
  - IDLE: a non-MUL valid instruction loads EX/MEM with its ALU result.
  - IDLE with in_valid and aluop=MUL, no flush, no hold: stall_req=1 combinationally. Latch opA and opB into the multiplier, count=0, go to MUL_RUN. EX/MEM loads a bubble.
  - MUL_RUN: one shift-add step per cycle. stall_req=1. EX/MEM loads a bubble each cycle. When count reaches MUL_CYCLES-1, go to MUL_DONE.
  - MUL_DONE: stall_req=0. EX/MEM loads the product with the held ID/EX control, then go to IDLE.
- A bubble means exmem_valid, regwrite, memread and memwrite are all 0; rd, result and store_data are 0.
- Invalid input (in_valid=0) loads a bubble.
- Priority: rst > flush > hold > normal.
  - flush: EX/MEM loads a bubble and the FSM goes to IDLE, aborting any multiply. stall_req is 0 during a flush cycle.
  - hold: EX/MEM, FSM, count and multiplier registers all keep their values. stall_req keeps its state-derived value.

## Timing
- Reset: all EX/MEM outputs are 0, FSM is IDLE, count is 0, stall_req is 0.
- Non-MUL latency: ID/EX in cycle N gives the result on exmem_* in cycle N+1.
- MUL latency: presented in cycle 0.
  - stall_req is high in cycles 0..MUL_CYCLES (33 cycles).
  - MUL_DONE occurs in cycle MUL_CYCLES+1.
  - The product is on exmem_* in cycle MUL_CYCLES+2.
  - Each cycle of hold extends this by one.
- Operands are latched in cycle 0. Later changes in forwarding as bubbles drain do not affect the product.
- Back-to-back MULs: the second begins in the cycle after MUL_DONE, with no idle gap.
- rst asserted mid-multiply takes effect on the next edge, as at reset.

## Structure
- Package ex_pkg holds the ALU op codes, the forward-select constants (FWD_REG, FWD_MEM, FWD_WB) and the FSM state enum. It is shared with the decoder and the forwarding unit.
- Sub-module mul_iter holds the shift-add multiplier: multiplicand, multiplier, accumulator and count, with start/hold/abort inputs and a done output.
- The ALU and forwarding muxes stay inline as combinational logic.

## Test plan
- ADD with forwardA=10, exmem_fwd_data=5, in_rs2_data=7, alusrc=0 -> exmem_alu_result=12 one cycle later; exmem_rd and regwrite are propagated.
- SW with forwardB=01, wb_fwd_data=0xDEADBEEF, imm=8, opA=0x100 -> result=0x108, store_data=0xDEADBEEF, memwrite=1.
- MUL with opA=0xFFFFFFFF, opB=3 -> stall_req high for 33 cycles, exmem_valid=0 throughout, then result=0xFFFFFFFD in cycle 34.
- MUL with flush pulsed in cycle 10 -> FSM back to IDLE, stall_req=0 in cycle 10, EX/MEM bubble, no product ever emitted.
- MUL with hold high in cycles 5–7 -> product appears 3 cycles later (cycle 37) with the value unchanged; rst in cycle 20 of a new MUL -> all outputs 0 next cycle.
